fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_queue.sv | 54 +++++
 rtl/fetch_unit.sv | 84 ++++++++
 tb/tb_fetch_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package fetch_pkg;

    localparam int DEFAULT_PC_WIDTH          = 48;
    localparam int DEFAULT_INSTRUCTION_WIDTH = 48;
    localparam int DEFAULT_QUEUE_DEPTH       = 4;
    localparam int DEFAULT_PC_STEP           = 1;

    localparam logic [DEFAULT_INSTRUCTION_WIDTH-1:0] NOP_INSTRUCTION = '0;

    typedef struct packed {
        logic [DEFAULT_INSTRUCTION_WIDTH-1:0] instruction;
        logic [DEFAULT_PC_WIDTH-1:0]          pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch FIFO: head/tail wrap naturally, flush clears it in one cycle.
module fetch_queue #(
    parameter  int DEPTH  = 4,
    parameter  int DATA_W = 96,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic              full;
    logic              pop_ok;
    logic              push_ok;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign pop_ok    = pop && !empty;
    assign push_ok   = push && (!full || pop_ok);
    assign head_data = mem[head];

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_ok) tail <= tail + 1'b1;
            if (pop_ok)  head <= head + 1'b1;
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // Storage has no reset; only entries between head and tail are ever read.
    always_ff @(posedge clock) begin
        if (push_ok) mem[tail] <= push_data;
    end

    // The issue rule upstream guarantees a free slot for every returning word.
    always_ff @(posedge clock) begin
        if (!reset && !flush) assert (!(push && full && !pop_ok));
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC generation, one outstanding imem read, prefetch queue to Decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH          = DEFAULT_PC_WIDTH,
    parameter int INSTRUCTION_WIDTH = DEFAULT_INSTRUCTION_WIDTH,
    parameter int QUEUE_DEPTH       = DEFAULT_QUEUE_DEPTH,
    parameter int PC_STEP           = DEFAULT_PC_STEP
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         takeBranch,
    input  logic [PC_WIDTH-1:0]          branchTarget,
    output logic [PC_WIDTH-1:0]          imemAddress,
    output logic                         imemReadEnable,
    input  logic [INSTRUCTION_WIDTH-1:0] imemData,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic [PC_WIDTH-1:0]          instructionPC,
    output logic                         instructionValid
);

    localparam int CNT_W   = $clog2(QUEUE_DEPTH + 1);
    localparam int ENTRY_W = INSTRUCTION_WIDTH + PC_WIDTH;

    logic [PC_WIDTH-1:0] fetch_pc;
    logic [PC_WIDTH-1:0] in_flight_pc;
    logic                in_flight;

    logic [ENTRY_W-1:0]  head_data;
    logic [CNT_W-1:0]    count;
    logic                empty;
    logic                pop;
    logic                push;
    logic                issue;
    logic [CNT_W:0]      occupancy;

    assign pop  = enable && !empty;
    assign push = in_flight && !takeBranch;

    // Slots already promised = queued words plus the read in flight, minus this cycle's pop.
    assign occupancy = {1'b0, count} + (CNT_W+1)'(in_flight) - (CNT_W+1)'(pop);
    assign issue     = !reset && !takeBranch && (occupancy < (CNT_W+1)'(QUEUE_DEPTH));

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc     <= '0;
            in_flight    <= 1'b0;
            in_flight_pc <= '0;
        end else if (takeBranch) begin
            fetch_pc  <= branchTarget;
            in_flight <= 1'b0;
        end else if (issue) begin
            fetch_pc     <= fetch_pc + PC_WIDTH'(PC_STEP);
            in_flight    <= 1'b1;
            in_flight_pc <= fetch_pc;
        end else begin
            in_flight <= 1'b0;
        end
    end

    fetch_queue #(
        .DEPTH  (QUEUE_DEPTH),
        .DATA_W (ENTRY_W)
    ) u_queue (
        .clock     (clock),
        .reset     (reset),
        .flush     (takeBranch),
        .push      (push),
        .push_data ({imemData, in_flight_pc}),
        .pop       (pop),
        .head_data (head_data),
        .count     (count),
        .empty     (empty)
    );

    assign imemAddress      = fetch_pc;
    assign imemReadEnable   = issue;
    assign instructionValid = !empty;
    assign instruction      = empty ? INSTRUCTION_WIDTH'(NOP_INSTRUCTION)
                                    : head_data[ENTRY_W-1 -: INSTRUCTION_WIDTH];
    assign instructionPC    = empty ? '0 : head_data[PC_WIDTH-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a queue-level reference model checked every cycle.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int PW    = 48;
    localparam int IW    = 48;
    localparam int DEPTH = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          takeBranch = 1'b0;
    logic [PW-1:0] branchTarget = '0;
    logic [PW-1:0] imemAddress;
    logic          imemReadEnable;
    logic [IW-1:0] imemData = '0;
    logic [IW-1:0] instruction;
    logic [PW-1:0] instructionPC;
    logic          instructionValid;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    fetch_unit dut (
        .clock            (clock),
        .reset            (reset),
        .enable           (enable),
        .takeBranch       (takeBranch),
        .branchTarget     (branchTarget),
        .imemAddress      (imemAddress),
        .imemReadEnable   (imemReadEnable),
        .imemData         (imemData),
        .instruction      (instruction),
        .instructionPC    (instructionPC),
        .instructionValid (instructionValid)
    );

    // Instruction memory: word at address a holds a + 100, one-cycle read latency.
    always @(posedge clock) begin
        if (imemReadEnable) imemData <= imemAddress + 48'd100;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: queue of {word, pc}, one outstanding read, next PC.
    fetch_entry_t  mq[$];
    logic [PW-1:0] m_pc = '0;
    logic [PW-1:0] m_ifpc = '0;
    bit            m_if = 0;
    bit            model_ok = 0;

    function automatic bit m_pop();
        return enable && (mq.size() != 0);
    endfunction

    function automatic bit m_issue();
        int promised;
        promised = mq.size() + int'(m_if) - int'(m_pop());
        return !reset && !takeBranch && (promised < DEPTH);
    endfunction

    always @(posedge clock) begin
        bit iss;
        bit pp;
        if (reset) begin
            mq.delete();
            m_pc     = '0;
            m_if     = 0;
            model_ok = 1;
        end else if (takeBranch) begin
            mq.delete();
            m_if = 0;
            m_pc = branchTarget;
        end else begin
            iss = m_issue();
            pp  = m_pop();
            if (pp) void'(mq.pop_front());
            if (m_if) mq.push_back('{instruction: m_ifpc + 48'd100, pc: m_ifpc});
            if (iss) begin
                m_ifpc = m_pc;
                m_pc   = m_pc + 48'd1;
                m_if   = 1;
            end else begin
                m_if = 0;
            end
        end
    end

    always @(negedge clock) begin
        bit ev;
        if (model_ok) begin
            ev = (mq.size() != 0);
            chk("m_valid", instructionValid, ev);
            chk("m_instr", instruction, ev ? mq[0].instruction : 48'd0);
            chk("m_pc", instructionPC, ev ? mq[0].pc : 48'd0);
            chk("m_rden", imemReadEnable, m_issue());
            if (m_issue()) chk("m_addr", imemAddress, m_pc);
        end
    end

    task automatic tick(input bit rst, input bit en, input bit br, input logic [PW-1:0] tgt);
        @(posedge clock);
        #1;
        reset        = rst;
        enable       = en;
        takeBranch   = br;
        branchTarget = tgt;
        @(negedge clock);
    endtask

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

    initial begin
        int  nreads;
        int  npop;
        bit  pat [5];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        // Reset state
        tick(1, 0, 0, '0);
        tick(1, 0, 0, '0);
        chk("rst_valid", instructionValid, 0);
        chk("rst_rden", imemReadEnable, 0);
        chk("rst_instr", instruction, 0);
        chk("rst_ipc", instructionPC, 0);
        chk("rst_addr", imemAddress, 0);

        // Streaming from reset: first word visible two cycles after release
        tick(0, 1, 0, '0);
        chk("t1_c0_rden", imemReadEnable, 1);
        chk("t1_c0_addr", imemAddress, 0);
        chk("t1_c0_valid", instructionValid, 0);
        tick(0, 1, 0, '0);
        chk("t1_c1_valid", instructionValid, 0);
        chk("t1_c1_addr", imemAddress, 1);
        tick(0, 1, 0, '0);
        chk("t1_c2_valid", instructionValid, 1);
        chk("t1_c2_instr", instruction, 100);
        chk("t1_c2_pc", instructionPC, 0);
        tick(0, 1, 0, '0);
        chk("t1_c3_instr", instruction, 101);
        chk("t1_c3_pc", instructionPC, 1);
        tick(0, 1, 0, '0);
        chk("t1_c4_instr", instruction, 102);
        chk("t1_c4_pc", instructionPC, 2);

        // Stall from reset: exactly four reads, head held, resume on first pop
        tick(1, 0, 0, '0);
        nreads = 0;
        for (int c = 0; c < 6; c++) begin
            tick(0, 0, 0, '0);
            if (imemReadEnable) begin
                chk("t2_addr", imemAddress, nreads);
                nreads++;
            end
        end
        chk("t2_reads", nreads, 4);
        chk("t2_head_instr", instruction, 100);
        chk("t2_head_pc", instructionPC, 0);
        tick(0, 1, 0, '0);
        chk("t2_resume_rden", imemReadEnable, 1);
        chk("t2_resume_addr", imemAddress, 4);
        chk("t2_resume_instr", instruction, 100);
        for (int c = 0; c < 5; c++) tick(0, 1, 0, '0);

        // Branch with queue=3 and a read in flight
        tick(1, 0, 0, '0);
        for (int c = 0; c < 4; c++) tick(0, 0, 0, '0);
        tick(0, 0, 1, 48'h40);
        chk("t3_b_rden", imemReadEnable, 0);
        tick(0, 0, 0, '0);
        chk("t3_b1_valid", instructionValid, 0);
        chk("t3_b1_rden", imemReadEnable, 1);
        chk("t3_b1_addr", imemAddress, 48'h40);
        tick(0, 0, 0, '0);
        chk("t3_b2_valid", instructionValid, 0);
        chk("t3_b2_addr", imemAddress, 48'h41);
        tick(0, 0, 0, '0);
        chk("t3_b3_valid", instructionValid, 1);
        chk("t3_b3_pc", instructionPC, 48'h40);
        chk("t3_b3_instr", instruction, 48'hA4);

        // Branch together with enable on a non-empty queue
        tick(0, 1, 0, '0);
        chk("t4_pre_pc", instructionPC, 48'h40);
        tick(0, 1, 1, 48'h200);
        chk("t4_b_valid", instructionValid, 1);
        chk("t4_b_pc", instructionPC, 48'h41);
        chk("t4_b_rden", imemReadEnable, 0);
        tick(0, 1, 0, '0);
        chk("t4_b1_valid", instructionValid, 0);
        chk("t4_b1_instr", instruction, 0);
        chk("t4_b1_addr", imemAddress, 48'h200);
        tick(0, 1, 0, '0);
        tick(0, 1, 0, '0);
        chk("t4_b3_pc", instructionPC, 48'h200);

        // PC wraps modulo 2^48
        tick(0, 1, 1, 48'hFFFF_FFFF_FFFF);
        tick(0, 1, 0, '0);
        chk("wrap_addr_hi", imemAddress, 48'hFFFF_FFFF_FFFF);
        tick(0, 1, 0, '0);
        chk("wrap_addr_lo", imemAddress, 0);
        tick(0, 1, 0, '0);
        chk("wrap_pc_hi", instructionPC, 48'hFFFF_FFFF_FFFF);
        chk("wrap_instr_hi", instruction, 99);
        tick(0, 1, 0, '0);
        chk("wrap_pc_lo", instructionPC, 0);

        // Ten instructions under a 1,0,1,1,0 enable pattern
        tick(1, 0, 0, '0);
        npop = 0;
        for (int i = 0; i < 60 && npop < 10; i++) begin
            tick(0, pat[i % 5], 0, '0);
            if (instructionValid && enable) begin
                chk("t5_seq_pc", instructionPC, npop);
                chk("t5_seq_instr", instruction, npop + 100);
                npop++;
            end
        end
        chk("t5_pops", npop, 10);

        // Reset mid-stream with three words queued
        tick(1, 0, 0, '0);
        for (int c = 0; c < 4; c++) tick(0, 0, 0, '0);
        chk("t6_pre_valid", instructionValid, 1);
        tick(1, 0, 0, '0);
        chk("t6_r0_rden", imemReadEnable, 0);
        tick(1, 0, 0, '0);
        chk("t6_r1_valid", instructionValid, 0);
        chk("t6_r1_rden", imemReadEnable, 0);
        tick(0, 1, 0, '0);
        chk("t6_rel_rden", imemReadEnable, 1);
        chk("t6_rel_addr", imemAddress, 0);
        chk("t6_rel_valid", instructionValid, 0);
        tick(0, 1, 0, '0);
        tick(0, 1, 0, '0);
        chk("t6_first_pc", instructionPC, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
